// File: rtl/target_pin_arbiter.sv
// Round-robin owner of the shared target programming pins (nRST, MOSI, SCK, PDID, PDIC)
// with undriven turnaround between owners, an inactivity watchdog and forced release on power-off.
module target_pin_arbiter #(
  parameter int unsigned TURN_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 50000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [2:0]  req_i,
  input  logic [2:0]  done_i,
  input  logic [2:0]  activity_i,
  input  logic [14:0] req_val_i,
  input  logic [14:0] req_oe_i,
  input  logic        target_highz_i,
  output logic [2:0]  grant_o,
  output logic        busy_o,
  output logic        timeout_pulse_o,
  output logic [4:0]  pin_val_o,
  output logic [4:0]  pin_oe_o
);

  // state   | meaning
  // IDLE    | no owner, pins undriven, arbitrating pending requests
  // SETTLE  | winner latched, pins held undriven for TURN_CYCLES cycles
  // GRANTED | winner owns the pins, watchdog running
  // RELEASE | owner gone, pins held undriven for TURN_CYCLES cycles
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_GRANTED = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [7:0]  TURN_LD = 8'(TURN_CYCLES);
  localparam logic [15:0] TO_LD   = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] wdog_q, wdog_d;
  logic [2:0]  grant_q, grant_d;
  logic        tmo_q, tmo_d;
  logic [4:0]  pin_val_q, pin_val_d;
  logic [4:0]  pin_oe_q, pin_oe_d;

  logic [2:0]  win_oh;
  logic [4:0]  val_sl, oe_sl;
  logic        own_req, own_done, own_act, wd_expire;

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    case (last)
      2'd0:    rr_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    rr_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: rr_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  endfunction

  always_comb begin
    win_oh = 3'b001;
    val_sl = req_val_i[4:0];
    oe_sl  = req_oe_i[4:0];
    case (winner_q)
      2'd1: begin
        win_oh = 3'b010;
        val_sl = req_val_i[9:5];
        oe_sl  = req_oe_i[9:5];
      end
      2'd2: begin
        win_oh = 3'b100;
        val_sl = req_val_i[14:10];
        oe_sl  = req_oe_i[14:10];
      end
      default: ;
    endcase
  end

  assign own_req   = |(req_i & win_oh);
  assign own_done  = |(done_i & win_oh);
  assign own_act   = |(activity_i & win_oh);
  assign wd_expire = !own_act && (wdog_q <= 16'd1);

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!target_highz_i && (req_i != 3'b000)) begin
          winner_d = rr_pick(last_q, req_i);
          cnt_d    = TURN_LD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        // an aborted settle leaves the pointer alone so the order is unchanged
        if (!own_req || target_highz_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= 8'd1) begin
          state_d = ST_GRANTED;
          last_d  = winner_q;
          wdog_d  = TO_LD;
        end
      end
      ST_GRANTED: begin
        wdog_d = own_act ? TO_LD : (wdog_q - 16'd1);
        if (own_done || !own_req || target_highz_i || wd_expire) begin
          state_d = ST_RELEASE;
          cnt_d   = TURN_LD;
          tmo_d   = wd_expire && !own_done && own_req && !target_highz_i;
        end
      end
      ST_RELEASE: begin
        if (cnt_q <= 8'd1) state_d = ST_IDLE;
        else cnt_d = cnt_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d   = 3'b000;
    pin_oe_d  = 5'b00000;
    pin_val_d = 5'b00000;
    if (state_d == ST_GRANTED) begin
      grant_d   = win_oh;
      pin_oe_d  = oe_sl;
      pin_val_d = val_sl & oe_sl;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      winner_q  <= 2'd0;
      last_q    <= 2'd2;
      cnt_q     <= 8'd0;
      wdog_q    <= 16'd0;
      grant_q   <= 3'b000;
      tmo_q     <= 1'b0;
      pin_val_q <= 5'b00000;
      pin_oe_q  <= 5'b00000;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      grant_q   <= grant_d;
      tmo_q     <= tmo_d;
      pin_val_q <= pin_val_d;
      pin_oe_q  <= pin_oe_d;
    end
  end

  assign grant_o         = grant_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign timeout_pulse_o = tmo_q;
  assign pin_val_o       = pin_val_q;
  assign pin_oe_o        = pin_oe_q;

endmodule

// File: tb/tb_target_pin_arbiter.sv
// Scoreboard bench for target_pin_arbiter: stimulus queues expected grant/timeout changes,
// a negedge monitor pops and compares them against the pins whenever the outputs change.
module tb_target_pin_arbiter;

  typedef struct packed {
    logic [2:0] g;
    logic       tmo;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, done, act;
  logic [14:0] rv, roe;
  logic        highz;
  logic [2:0]  grant;
  logic        busy, tmo;
  logic [4:0]  pval, poe;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  exp_t sb[$];
  logic [3:0] prev_ev = 4'b0000;
  logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  target_pin_arbiter #(.TURN_CYCLES(4), .TIMEOUT(20)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .req_i(req), .done_i(done), .activity_i(act),
    .req_val_i(rv), .req_oe_i(roe), .target_highz_i(highz),
    .grant_o(grant), .busy_o(busy), .timeout_pulse_o(tmo),
    .pin_val_o(pval), .pin_oe_o(poe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] exp_oe(input logic [2:0] g);
    case (g)
      3'b001:  return 5'b10111;
      3'b010:  return 5'b11011;
      3'b100:  return 5'b01111;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] exp_val(input logic [2:0] g);
    case (g)
      3'b001:  return 5'b10101;
      3'b010:  return 5'b01010;
      3'b100:  return 5'b01001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic check(input string name, input int act_v, input int exp_v);
    nchk++;
    if (act_v !== exp_v) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  task automatic push(input logic [2:0] g, input logic t, input int c);
    exp_t e;
    e.g   = g;
    e.tmo = t;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t e;
    logic [3:0] cur;
    forever begin
      @(negedge clk);
      cur = {tmo, grant};
      if (cur !== prev_ev) begin
        prev_ev = cur;
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_event: actual grant=%b timeout=%b at cycle %0d, required no change",
                   grant, tmo, cyc);
        end else begin
          e = sb.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("grant", 32'(grant), 32'(e.g));
          check("timeout_pulse", 32'(tmo), 32'(e.tmo));
          check("pin_oe", 32'(poe), 32'(exp_oe(e.g)));
          check("pin_val", 32'(pval), 32'(exp_val(e.g)));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int b, m, t, g, h, p, q, r, s;
    rst_n = 1'b0;
    req   = 3'b000;
    done  = 3'b000;
    act   = 3'b000;
    highz = 1'b0;
    rv    = {5'b11001, 5'b01110, 5'b10101};
    roe   = {5'b01111, 5'b11011, 5'b10111};

    @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(tmo), 0);
    check("rst_pin_oe", 32'(poe), 0);
    check("rst_pin_val", 32'(pval), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // first grant latency and done release
    b = cyc;
    req = 3'b001;
    push(3'b001, 1'b0, b + 5);
    push(3'b000, 1'b0, b + 8);
    check("busy_idle", 32'(busy), 0);
    goto(b + 1);
    check("busy_after_req", 32'(busy), 1);
    goto(b + 7);
    done = 3'b001;
    goto(b + 8);
    done = 3'b000;
    req  = 3'b000;

    // round robin from reset with all requesting
    goto(b + 20);
    rst_n = 1'b0;
    goto(b + 22);
    rst_n = 1'b1;
    m = cyc;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      push(seq[k], 1'b0, m + 5 + 20 * k);
      push(3'b000, 1'b0, m + 16 + 20 * k);
    end
    for (int k = 0; k < 4; k++) begin
      goto(m + 15 + 20 * k);
      done = seq[k];
      if (k == 3) req = 3'b000;
      goto(m + 16 + 20 * k);
      done = 3'b000;
    end

    // watchdog release, non-owner done/activity ignored, then kept alive by activity
    goto(m + 85);
    t = cyc;
    req = 3'b010;
    push(3'b010, 1'b0, t + 5);
    push(3'b000, 1'b1, t + 25);
    push(3'b000, 1'b0, t + 26);
    push(3'b010, 1'b0, t + 34);
    for (int c = t + 1; c <= t + 30; c++) begin
      goto(c);
      act  = (((c - t) % 6 == 0) && (c - t <= 24)) ? 3'b101 : 3'b000;
      done = (c == t + 10) ? 3'b001 : 3'b000;
    end
    g = t + 34;
    push(3'b000, 1'b0, g + 216);
    for (int c = g; c < g + 215; c++) begin
      goto(c);
      act = (((c - g) >= 14) && ((c - g - 14) % 15 == 0)) ? 3'b010 : 3'b000;
    end
    goto(g + 215);
    act = 3'b000;
    req = 3'b000;

    // target power-off forces release and blocks arbitration
    goto(g + 225);
    h = cyc;
    req = 3'b111;
    push(3'b100, 1'b0, h + 5);
    push(3'b000, 1'b0, h + 9);
    goto(h + 8);
    highz = 1'b1;
    goto(h + 20);
    check("highz_busy", 32'(busy), 0);
    check("highz_grant", 32'(grant), 0);
    goto(h + 40);
    req   = 3'b000;
    highz = 1'b0;

    // done coinciding with watchdog expiry suppresses the timeout pulse
    goto(h + 45);
    p = cyc;
    req = 3'b001;
    push(3'b001, 1'b0, p + 5);
    push(3'b000, 1'b0, p + 25);
    goto(p + 24);
    done = 3'b001;
    goto(p + 25);
    done = 3'b000;
    req  = 3'b000;

    // request withdrawn during settle: no grant, pointer unchanged
    goto(p + 40);
    q = cyc;
    req = 3'b010;
    goto(q + 2);
    req = 3'b000;
    goto(q + 5);
    check("settle_abort_busy", 32'(busy), 0);
    goto(q + 10);
    req = 3'b111;
    push(3'b010, 1'b0, q + 15);
    push(3'b000, 1'b0, q + 18);
    goto(q + 17);
    req = 3'b000;

    // asynchronous reset mid-grant, then pointer restarts at requester 0
    goto(q + 30);
    r = cyc;
    req = 3'b100;
    push(3'b100, 1'b0, r + 5);
    push(3'b000, 1'b0, r + 8);
    goto(r + 8);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 0);
    check("async_rst_pin_oe", 32'(poe), 0);
    check("async_rst_busy", 32'(busy), 0);
    req = 3'b110;
    goto(r + 11);
    rst_n = 1'b1;
    s = cyc;
    push(3'b010, 1'b0, s + 5);
    push(3'b000, 1'b0, s + 8);
    goto(s + 7);
    req = 3'b000;
    goto(s + 15);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/target_pin_arbiter.md
Name: target_pin_arbiter

Overview:
- Shares the target programming/control pins (nRST, MOSI, SCK, PDID, PDIC) between three requesters:
  - 0: AVR ISP engine
  - 1: XMEGA PDI engine
  - 2: register-controlled GPIO
- Round-robin grant with a request/grant handshake, guaranteed high-Z turnaround between owners, an inactivity watchdog, and forced release whenever the target is unpowered.
- Sits between the requesters and the top-level pin tristate assigns, replacing ad-hoc priority muxing there.

Parameters:
- TURN_CYCLES, 4: undriven settle cycles before each grant and after each release; legal 1..255.
- TIMEOUT, 50000: cycles without owner activity before forced release; legal 1..65535.

Ports:
- clk  input  1  system clock (clk_usb domain); all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  3  level request per requester; bit i = requester i.
- done  input  3  one-cycle release pulse per requester; ignored unless that requester is the owner.
- activity  input  3  owner heartbeat; any cycle high reloads the watchdog; ignored for non-owners.
- req_val  input  15  pin values, 5 bits per requester; requester i uses [5i+4:5i]; bit order {PDIC,PDID,SCK,MOSI,nRST}.
- req_oe  input  15  pin output enables, same packing.
- target_highz  input  1  target power off; forces release and blocks new grants.
- grant  output  3  one-hot owner, registered.
- busy  output  1  high in every state except IDLE.
- timeout_pulse  output  1  one-cycle pulse on watchdog release.
- pin_val  output  5  registered pin values.
- pin_oe  output  5  registered pin enables; a bit of 0 means the top level tristates that pin.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; grant=0; busy=0; timeout_pulse=0; pin_val=0; pin_oe=0.
  - Round-robin pointer last=2, so requester 0 wins first; turnaround counter=0; watchdog=0.
- IDLE:
  - If target_highz=0 and req!=0, choose winner = first set bit searching from (last+1) mod 3 upward, wrapping.
  - Latch winner, load turnaround counter=TURN_CYCLES, go to SETTLE.
- SETTLE:
  - grant=0, pin_oe=0; decrement counter each cycle.
  - At count 0 go to GRANTED and set last=winner.
  - If req[winner] drops or target_highz=1, return to IDLE; the pointer is not updated.
- GRANTED:
  - grant=onehot(winner).
  - Watchdog reloads to TIMEOUT on entry and on any cycle with activity[winner]=1, else decrements.
  - Exit to RELEASE when any of the following holds: done[winner]=1, req[winner]=0, target_highz=1, or watchdog reaches 0.
  - Simultaneous exit causes: timeout_pulse fires only if the watchdog is the sole cause. done or activity in the same cycle as expiry suppresses the timeout.
- RELEASE:
  - grant=0, pin_oe=0; count TURN_CYCLES cycles, then go to IDLE.
  - A request already pending in IDLE is evaluated on the first IDLE cycle (one IDLE cycle minimum between owners).
- Pin register timing:
  - pin_val/pin_oe load {req_val,req_oe} slice of winner when next_state==GRANTED, else load 0.
  - So grant and pins switch on the same edge, and pins are one cycle behind requester vectors.
  - pin_val is 0 whenever pin_oe is 0.
- Latency and turnaround:
  - req rising in IDLE at cycle 0 gives grant and pins at cycle TURN_CYCLES+1.
  - done at cycle k gives grant=0 and pin_oe=0 at cycle k+1.
  - Pins are undriven for at least TURN_CYCLES+1 cycles between any two owners.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous); no pulse generated.
- Non-owner done/activity inputs have no effect.
- grant is always one-hot or zero.

Test Plan:
- TURN_CYCLES=4, req=001 at cycle 0 from reset → grant=001 at cycle 5; pin_oe=req_oe[4:0] from cycle 5; busy high from cycle 1.
- req=111 held, each owner pulses done 10 cycles after grant → grant sequence 001,010,100,001; pin_oe=0 for ≥5 cycles between owners.
- TIMEOUT=20, owner 1 with no activity → release 20 cycles after grant; timeout_pulse exactly one cycle; grant=0 next cycle. Repeat with activity every 15 cycles → no release after 200 cycles.
- target_highz=1 during GRANTED → grant=0 and pin_oe=0 next cycle. While highz=1 with req=111 → stays IDLE/RELEASE, no grant.
- done and watchdog expiry in the same cycle → release, timeout_pulse stays 0. req[winner] dropped during SETTLE → IDLE, and the next grant order is unchanged.
- reset_n asserted asynchronously mid-GRANTED (between edges) → grant, pin_oe, busy=0 immediately. After deassert with req=110 → requester 1 granted first.
